// File: rtl/gba_eeprom_backup.sv
// gba_eeprom_backup: watches the EEPROM save block for completed writes,
// waits for the game to go quiet (or for an explicit request), then reads
// the whole save image through the EEPROM side port and streams it out as
// a valid/ready byte stream for the SD writer.
//
// Stream handshake: a byte transfers on a rising clk edge where out_valid
// and out_ready are both high. Once out_valid rises, out_data, out_addr and
// out_last hold steady until that transfer, and out_valid never drops
// without it (except on rst).
module gba_eeprom_backup #(
   parameter int QUIET_CYCLES = 4000000,
   parameter int QW           = 23
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        model,
   input  logic        written,
   input  logic        flush_req,
   output logic        rv_rd,
   output logic        rv_wr,
   output logic [12:0] rv_addr,
   output logic [7:0]  rv_wdata,
   input  logic [7:0]  rv_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic [12:0] out_addr,
   output logic        out_last,
   output logic        busy,
   output logic        dirty,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_QUIET = 3'd1,
      S_RD    = 3'd2,
      S_CAP   = 3'd3,
      S_SEND  = 3'd4
   } state_t;

   localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

   state_t        state_q;
   logic [QW-1:0] quiet_q;
   logic [12:0]   ptr_q;
   logic          big_q;       // latched save size: 1 = 8 KiB image
   logic          dirty_q;
   logic          pending_q;   // a write landed while a flush was running
   logic          rv_rd_q;
   logic [12:0]   rv_addr_q;
   logic          out_valid_q;
   logic [7:0]    out_data_q;
   logic [12:0]   out_addr_q;
   logic          out_last_q;

   logic [12:0]   last_addr;
   logic [12:0]   ptr_inc;
   logic          pending_d;

   // Derived values used by the sequencer below
   always_comb begin
      last_addr = big_q ? 13'h1FFF : 13'h01FF;
      ptr_inc   = ptr_q + 13'd1;
      // A write arriving on the final handshake still counts as pending
      pending_d = pending_q | written;
   end

   // Flush sequencer: quiet-wait, then read/capture/send one byte at a time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         quiet_q     <= '0;
         ptr_q       <= '0;
         big_q       <= 1'b0;
         dirty_q     <= 1'b0;
         pending_q   <= 1'b0;
         rv_rd_q     <= 1'b0;
         rv_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // A write coinciding with the request is already in memory,
               // so the flush about to start covers it.
               if (flush_req && (dirty_q || written)) begin
                  state_q   <= S_RD;
                  ptr_q     <= '0;
                  big_q     <= model;
                  dirty_q   <= 1'b0;
                  pending_q <= 1'b0;
                  rv_rd_q   <= 1'b1;
                  rv_addr_q <= '0;
               end else if (written) begin
                  dirty_q <= 1'b1;
                  quiet_q <= '0;
                  state_q <= S_QUIET;
               end
            end
            S_QUIET: begin
               if (flush_req || (!written && quiet_q == QUIET_LAST)) begin
                  state_q   <= S_RD;
                  ptr_q     <= '0;
                  big_q     <= model;
                  dirty_q   <= 1'b0;
                  pending_q <= 1'b0;
                  rv_rd_q   <= 1'b1;
                  rv_addr_q <= '0;
               end else if (written) begin
                  quiet_q <= '0;
               end else begin
                  quiet_q <= quiet_q + QW'(1);
               end
            end
            S_RD: begin
               if (written) begin
                  pending_q <= 1'b1;
                  dirty_q   <= 1'b1;
               end
               rv_rd_q <= 1'b0;
               state_q <= S_CAP;
            end
            S_CAP: begin
               if (written) begin
                  pending_q <= 1'b1;
                  dirty_q   <= 1'b1;
               end
               out_data_q  <= rv_rdata;
               out_addr_q  <= ptr_q;
               out_last_q  <= (ptr_q == last_addr);
               out_valid_q <= 1'b1;
               state_q     <= S_SEND;
            end
            S_SEND: begin
               if (written) begin
                  pending_q <= 1'b1;
                  dirty_q   <= 1'b1;
               end
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (out_last_q) begin
                     pending_q <= 1'b0;
                     if (pending_d) begin
                        dirty_q <= 1'b1;
                        quiet_q <= '0;
                        state_q <= S_QUIET;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     ptr_q     <= ptr_inc;
                     rv_rd_q   <= 1'b1;
                     rv_addr_q <= ptr_inc;
                     state_q   <= S_RD;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rv_rd     = rv_rd_q;
   assign rv_wr     = 1'b0;
   assign rv_addr   = rv_addr_q;
   assign rv_wdata  = 8'h00;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_IDLE);
   assign dirty     = dirty_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_gba_eeprom_backup.sv
// Bench for gba_eeprom_backup: a byte-addressed memory model answers the
// side port, stimulus pushes the expected save image into a queue, and a
// negedge monitor pops and compares every transferred byte.
module tb_gba_eeprom_backup;

   localparam int QC = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        model;
   logic        written;
   logic        flush_req;
   logic        rv_rd;
   logic        rv_wr;
   logic [12:0] rv_addr;
   logic [7:0]  rv_wdata;
   logic [7:0]  rv_rdata = 8'h00;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [12:0] out_addr;
   logic        out_last;
   logic        busy;
   logic        dirty;
   logic [2:0]  dbg_state;

   gba_eeprom_backup #(.QUIET_CYCLES(QC), .QW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .model     (model),
      .written   (written),
      .flush_req (flush_req),
      .rv_rd     (rv_rd),
      .rv_wr     (rv_wr),
      .rv_addr   (rv_addr),
      .rv_wdata  (rv_wdata),
      .rv_rdata  (rv_rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_last  (out_last),
      .busy      (busy),
      .dirty     (dirty),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog cyc=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- memory model: byte[i] = i[7:0] ----------------
   logic [7:0] mem [0:8191];
   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = i[7:0];
   end
   initial forever begin
      @(posedge clk);
      if (rv_rd) rv_rdata <= mem[rv_addr];
   end

   // ---------------- consumer ready driver ----------------
   logic ready_mode = 1'b0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- scoreboard ----------------
   logic [21:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endfunction

   task automatic push_image(input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({(i == n - 1), 13'(i), 8'(i)});
   endtask

   // ---------------- monitor ----------------
   int          rd_entries = 0;
   int          rd_cyc = 0;
   logic [2:0]  prev_state = 3'd0;
   logic        held_v = 1'b0;
   logic [20:0] held = '0;

   initial forever begin
      logic [21:0] e;
      @(negedge clk);
      if (rst) begin
         held_v     = 1'b0;
         prev_state = 3'd0;
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stream_extra actual addr=%0d data=%0d required=no byte", out_addr, out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_last, out_addr, out_data} !== e) begin
                  errors++;
                  $display("FAIL stream_byte actual last=%0d addr=%0d data=%0d required last=%0d addr=%0d data=%0d",
                           out_last, out_addr, out_data, e[21], e[20:8], e[7:0]);
               end
            end
         end
         if (held_v && out_valid)
            chk("hold_stable", int'({out_addr, out_data}), int'(held));
         held_v = out_valid && !out_ready;
         held   = {out_addr, out_data};
         if (dbg_state == 3'd2 && (prev_state == 3'd0 || prev_state == 3'd1)) begin
            rd_entries++;
            rd_cyc = cyc;
         end
         prev_state = dbg_state;
         if (rv_wr) chk("rv_wr_low", int'(rv_wr), 0);
      end
   end

   // ---------------- driver tasks ----------------
   int w_cyc = 0;
   int f_cyc = 0;

   task automatic pulse_written();
      written = 1'b1;
      @(posedge clk);
      #1;
      w_cyc   = cyc;
      written = 1'b0;
   endtask

   task automatic pulse_flush();
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      f_cyc     = cyc;
      flush_req = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(n < budget), 1);
   endtask

   task automatic wait_addr(input string name, input int addr);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(out_valid && out_addr == 13'(addr)) && n < 3000);
      chk(name, int'(n < 3000), 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int first_w;
      int n;
      rst       = 1'b1;
      model     = 1'b0;
      written   = 1'b0;
      flush_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy",      int'(busy), 0);
      chk("rst_dirty",     int'(dirty), 0);
      chk("rst_rv_rd",     int'(rv_rd), 0);
      chk("rst_out_last",  int'(out_last), 0);
      chk("rst_out_addr",  int'(out_addr), 0);
      chk("rst_out_data",  int'(out_data), 0);
      chk("rst_rv_addr",   int'(rv_addr), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // auto flush after the quiet period, 512-byte image
      rd_entries = 0;
      push_image(512);
      pulse_written();
      @(negedge clk);
      chk("auto_dirty_set", int'(dirty), 1);
      chk("auto_busy_set",  int'(busy), 1);
      wait_idle("auto_done", 2500);
      chk("auto_rd_count",   rd_entries, 1);
      chk("auto_rd_latency", rd_cyc - w_cyc, QC);
      chk("auto_dirty_clr",  int'(dirty), 0);

      // coalescing: writes at t=0,10,20 give one flush at t=36
      rd_entries = 0;
      push_image(512);
      pulse_written();
      first_w = w_cyc;
      wait_cycles(9);
      pulse_written();
      wait_cycles(9);
      pulse_written();
      wait_idle("coal_done", 2500);
      chk("coal_rd_count", rd_entries, 1);
      chk("coal_rd_time",  rd_cyc - first_w, 36);

      // flush_req while clean does nothing
      rd_entries = 0;
      pulse_flush();
      wait_cycles(10);
      chk("clean_flush_busy", int'(busy), 0);
      chk("clean_flush_rd",   rd_entries, 0);

      // flush_req during QUIET starts RD on the next edge
      rd_entries = 0;
      push_image(512);
      pulse_written();
      wait_cycles(3);
      pulse_flush();
      wait_cycles(2);
      chk("req_rd_count",   rd_entries, 1);
      chk("req_rd_latency", rd_cyc - f_cyc, 0);
      wait_idle("req_done", 2500);

      // write during a flush: flush completes, then a second full flush
      rd_entries = 0;
      push_image(512);
      push_image(512);
      pulse_written();
      wait_addr("mid_find_100", 100);
      pulse_written();
      @(negedge clk);
      chk("mid_dirty_set", int'(dirty), 1);
      chk("mid_busy",      int'(busy), 1);
      n = 0;
      while (dbg_state != 3'd1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("mid_to_quiet",   int'(n < 3000), 1);
      chk("mid_quiet_dirty", int'(dirty), 1);
      chk("mid_first_done", exp_q.size(), 512);
      wait_idle("mid_done", 2500);
      chk("mid_rd_count",  rd_entries, 2);
      chk("mid_dirty_clr", int'(dirty), 0);

      // 8 KiB image under random backpressure; model flips mid-flush
      rd_entries = 0;
      model      = 1'b1;
      ready_mode = 1'b1;
      push_image(8192);
      pulse_written();
      wait_addr("bp_find_50", 50);
      model = 1'b0;
      wait_idle("bp_done", 60000);
      ready_mode = 1'b0;
      chk("bp_rd_count", rd_entries, 1);

      // reset at byte 37 aborts; a new write restarts from byte 0
      push_image(512);
      pulse_written();
      wait_addr("rst_find_37", 37);
      #1 rst = 1'b1;
      #1;
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_rv_rd",     int'(rv_rd), 0);
      chk("abort_busy",      int'(busy), 0);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      rd_entries = 0;
      push_image(512);
      pulse_written();
      wait_idle("restart_done", 2500);
      chk("restart_rd_count", rd_entries, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gba_eeprom_backup.md
Name: gba_eeprom_backup

Overview:
- Sits directly downstream of the GBA EEPROM save block.
- Consumes its `written` pulse and its 8-bit side port, then streams the whole save image out as a byte stream to the save-persistence path (SD writer).
- Waits until the game has stopped writing for a quiet period before flushing, which coalesces bursts of EEPROM writes into a single flush.
- Also accepts an explicit flush request.

Parameters:
- QUIET_CYCLES, 4000000, number of clk cycles without a `written` pulse before an automatic flush starts (≥2).
- QW, 23, width of the quiet counter; must satisfy 2^QW > QUIET_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- model  in  1  save size: 0 = 512 bytes, 1 = 8192 bytes; sampled when a flush starts
- written  in  1  one-cycle pulse from the EEPROM block on completion of a 64-bit write
- flush_req  in  1  pulse; flush now if dirty, skipping the quiet wait
- rv_rd  out  1  read strobe to the EEPROM side port
- rv_wr  out  1  write strobe; tied 0
- rv_addr  out  13  byte address to the EEPROM side port
- rv_wdata  out  8  tied 0
- rv_rdata  in  8  read data, valid exactly 1 cycle after rv_rd
- out_valid  out  1  byte stream valid
- out_ready  in  1  byte stream ready from the consumer
- out_data  out  8  save byte
- out_addr  out  13  byte offset of out_data
- out_last  out  1  high with the final byte of the image
- busy  out  1  high in any state except IDLE
- dirty  out  1  unflushed EEPROM writes exist

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; dirty=0; pending=0; quiet counter=0; byte pointer=0.
- Reset mid-flush aborts the flush with no further out_valid. Dirty data is lost; the upper layer re-flushes on the next write.
- States: IDLE, QUIET, RD, CAP, SEND.
- IDLE:
  - `written` → dirty=1, counter=0, go to QUIET.
  - flush_req with dirty=1 → go to RD.
  - flush_req with dirty=0 → ignored.
- QUIET:
  - `written` → counter=0.
  - Otherwise counter+1. When counter==QUIET_CYCLES-1 → go to RD.
  - flush_req → go to RD immediately.
- Entering RD from IDLE or QUIET: ptr=0; size latched as 512 (model=0) or 8192 (model=1); dirty=0; pending=0.
- RD: rv_rd=1 and rv_addr=ptr for one cycle, then go to CAP.
- CAP: register rv_rdata into out_data; out_addr=ptr; out_valid=1; go to SEND.
- SEND:
  - out_valid, out_data and out_addr stay stable until out_ready.
  - out_last=1 iff ptr==size-1.
  - On out_valid&out_ready: out_valid=0.
    - If the byte is last: go to IDLE if pending=0; if pending=1 set dirty=1, counter=0 and go to QUIET.
    - Otherwise ptr+1 and go to RD.
- `written` during RD/CAP/SEND sets pending=1 and dirty=1; the flush in progress continues unchanged.
- Throughput: at most one byte per 3 cycles. The first out_valid appears 2 cycles after entering RD.
- rv_rd is never asserted outside RD; rv_wr is never asserted.
- `written` and flush_req in the same IDLE cycle: flush_req wins, go to RD. The write is already in memory, so dirty is not re-set.
- `model` changes mid-flush have no effect.

Test Plan:
- Auto flush (QUIET_CYCLES=16, model=0, memory preloaded byte[i]=i[7:0]): single `written`, out_ready=1 → after 16 quiet cycles, 512 bytes are emitted with out_data==out_addr[7:0], out_last only at addr 0x1FF, then busy=0 and dirty=0.
- Coalescing: `written` at t=0, 10, 20 (QUIET_CYCLES=16) → RD is entered exactly once, at t=36.
- Backpressure (model=1): out_ready toggles pseudo-randomly → out_data and out_addr are stable while out_valid & ~out_ready, and exactly 8192 bytes are delivered in order, ending at addr 0x1FFF with out_last.
- Write during flush: `written` at byte 100 of a 512-byte flush → flush completes, state goes to QUIET with dirty=1, and a second full flush follows.
- flush_req: with dirty=0 → no activity; with dirty=1 during QUIET → RD is entered the next cycle.
- Reset at byte 37 of a flush → out_valid, rv_rd and busy drop to 0 immediately; a new `written` restarts the flush from ptr 0.
